coleco_ctrl_port: RTL and testbench

Controller-port sequencer between the keypad/joystick decoders and the Z80 I/O bus. It latches the CPU-selected controller mode (keypad or joystick) from I/O writes and answers controller-port reads with the ColecoVision byte format. It also stretches short keypad presses so the BIOS polling loop always sees them. The block sits between the PS/2 decoding blocks and the CPU I/O decode.

---
 rtl/coleco_ctrl_port.sv | 167 ++++++++++++++++
 tb/tb_coleco_ctrl_port.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/coleco_ctrl_port.sv
// ColecoVision controller-port sequencer: mode latch, keypad press stretcher, port read mux.
// Define COLECO_P2_EN to build the player-2 path; otherwise player-2 reads return 8'h7F.

module coleco_key_stretch #(
  parameter int HOLD_CYCLES = 400000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_in,
  output logic [3:0] code
);
  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // NOTE: every register in this design is updated with <= so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      code  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_in != 4'h0) begin
            state <= PRESS;
            code  <= key_in;
          end
        end
        PRESS: begin
          if (key_in == 4'h0) begin
            state <= HOLD;
            cnt   <= '0;
          end else if (key_in != code) begin
            code <= key_in;
          end
        end
        HOLD: begin
          // A new press wins over expiry so a re-press always restarts the hold window.
          if (key_in != 4'h0) begin
            state <= PRESS;
            code  <= key_in;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE;
            code  <= '0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          code  <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

module coleco_ctrl_port #(
  parameter int HOLD_CYCLES = 400000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] io_addr,
  input  logic       io_wr,
  input  logic       io_rd,
  output logic [7:0] io_dout,
  input  logic [3:0] p1_key,
  input  logic [4:0] p1_joy,
  input  logic       p1_fire_r,
  input  logic [3:0] p2_key,
  input  logic [4:0] p2_joy,
  input  logic       p2_fire_r,
  output logic       mode
);
  function automatic logic [7:0] port_byte(input logic       joy_mode,
                                           input logic [3:0] code,
                                           input logic [4:0] joy,
                                           input logic       fire_r);
    return joy_mode ? {1'b0, ~joy[4], 2'b11, ~joy[3:0]}
                    : {1'b0, ~fire_r, 2'b11, ~code};
  endfunction

  logic [3:0] p1_key_q;
  logic [4:0] p1_joy_q;
  logic       p1_fire_r_q;
  logic [3:0] p1_code;
  logic [7:0] p1_byte;
  logic [7:0] p2_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      p1_key_q    <= '0;
      p1_joy_q    <= '0;
      p1_fire_r_q <= 1'b0;
    end else begin
      p1_key_q    <= p1_key;
      p1_joy_q    <= p1_joy;
      p1_fire_r_q <= p1_fire_r;
    end
  end

  coleco_key_stretch #(.HOLD_CYCLES(HOLD_CYCLES)) u_p1_stretch (
    .clk    (clk),
    .reset  (reset),
    .key_in (p1_key_q),
    .code   (p1_code)
  );

  assign p1_byte = port_byte(mode, p1_code, p1_joy_q, p1_fire_r_q);

`ifdef COLECO_P2_EN
  logic [3:0] p2_key_q;
  logic [4:0] p2_joy_q;
  logic       p2_fire_r_q;
  logic [3:0] p2_code;

  always_ff @(posedge clk) begin
    if (reset) begin
      p2_key_q    <= '0;
      p2_joy_q    <= '0;
      p2_fire_r_q <= 1'b0;
    end else begin
      p2_key_q    <= p2_key;
      p2_joy_q    <= p2_joy;
      p2_fire_r_q <= p2_fire_r;
    end
  end

  coleco_key_stretch #(.HOLD_CYCLES(HOLD_CYCLES)) u_p2_stretch (
    .clk    (clk),
    .reset  (reset),
    .key_in (p2_key_q),
    .code   (p2_code)
  );

  assign p2_byte = port_byte(mode, p2_code, p2_joy_q, p2_fire_r_q);
`else
  logic unused_p2;
  assign unused_p2 = ^{p2_key, p2_joy, p2_fire_r};
  assign p2_byte   = 8'h7F;
`endif

  // The read mux sees the pre-edge mode, so a read alongside a mode write uses the old mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode    <= 1'b0;
      io_dout <= 8'hFF;
    end else begin
      if (io_wr && io_addr[7:5] == 3'b100) begin
        mode <= 1'b0;
      end else if (io_wr && io_addr[7:5] == 3'b110) begin
        mode <= 1'b1;
      end
      if (io_rd && io_addr[7:5] == 3'b111) begin
        io_dout <= io_addr[1] ? p2_byte : p1_byte;
      end
    end
  end
endmodule

// File: tb/tb_coleco_ctrl_port.sv
// Self-checking bench for coleco_ctrl_port with a short hold window (HOLD_CYCLES=16).
// Player-2 expectations follow COLECO_P2_EN.

module tb_coleco_ctrl_port;
  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] io_addr;
  logic       io_wr, io_rd;
  logic [7:0] io_dout;
  logic [3:0] p1_key, p2_key;
  logic [4:0] p1_joy, p2_joy;
  logic       p1_fire_r, p2_fire_r;
  logic       mode;

  int checks = 0;
  int fails  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_exp = 8'hFF;

  coleco_ctrl_port #(.HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .io_addr   (io_addr),
    .io_wr     (io_wr),
    .io_rd     (io_rd),
    .io_dout   (io_dout),
    .p1_key    (p1_key),
    .p1_joy    (p1_joy),
    .p1_fire_r (p1_fire_r),
    .p2_key    (p2_key),
    .p2_joy    (p2_joy),
    .p2_fire_r (p2_fire_r),
    .mode      (mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       joy_mode;
    logic [3:0] key;
    logic       fire_r;
    logic [4:0] joy;
    logic [7:0] addr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %02h, expected %02h", name, actual, expected);
    end
  endtask

  // Port read: the expected byte is queued at issue and popped once io_dout has updated.
  task automatic do_read(input string name, input logic [7:0] addr, input logic [7:0] exp);
    io_addr = addr;
    io_rd   = 1'b1;
    exp_q.push_back(exp);
    tick();
    io_rd = 1'b0;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      check(name, io_dout, exp_q.pop_front());
    end
    last_exp = exp;
  endtask

  task automatic do_write(input logic [7:0] addr);
    io_addr = addr;
    io_wr   = 1'b1;
    tick();
    io_wr = 1'b0;
  endtask

  initial begin
    logic [7:0] p2_kp, p2_js;
`ifdef COLECO_P2_EN
    p2_kp = 8'h71;
    p2_js = 8'h7A;
`else
    p2_kp = 8'h7F;
    p2_js = 8'h7F;
`endif

    vecs[0] = '{"kp_key5",     1'b0, 4'h5, 1'b0, 5'b00000, 8'hFC, 8'h7A};
    vecs[1] = '{"kp_key5_fire",1'b0, 4'h5, 1'b1, 5'b00000, 8'hFC, 8'h3A};
    vecs[2] = '{"kp_keyC",     1'b0, 4'hC, 1'b0, 5'b00000, 8'hFC, 8'h73};
    vecs[3] = '{"kp_key1_fd",  1'b0, 4'h1, 1'b0, 5'b00000, 8'hFD, 8'h7E};
    vecs[4] = '{"js_10011",    1'b1, 4'h1, 1'b0, 5'b10011, 8'hFC, 8'h3C};
    vecs[5] = '{"js_01100",    1'b1, 4'h1, 1'b1, 5'b01100, 8'hFC, 8'h73};
    vecs[6] = '{"js_00000",    1'b1, 4'h1, 1'b0, 5'b00000, 8'hFD, 8'h7F};
    vecs[7] = '{"js_11111",    1'b1, 4'h1, 1'b0, 5'b11111, 8'hFC, 8'h30};
    vecs[8] = '{"kp_back",     1'b0, 4'h1, 1'b0, 5'b11111, 8'hFC, 8'h7E};

    reset = 1'b1; io_addr = '0; io_wr = 1'b0; io_rd = 1'b0;
    p1_key = '0; p1_joy = '0; p1_fire_r = 1'b0;
    p2_key = '0; p2_joy = '0; p2_fire_r = 1'b0;

    // Reset state
    tick(2);
    reset = 1'b0;
    check("reset_dout", io_dout, 8'hFF);
    check("reset_mode", {7'd0, mode}, 8'h00);
    do_read("reset_read", 8'hFC, 8'h7F);

    // Table of steady-state reads in both modes
    for (int i = 0; i < 9; i++) begin
      if (mode !== vecs[i].joy_mode) do_write(vecs[i].joy_mode ? 8'hC0 : 8'h80);
      p1_key = vecs[i].key; p1_fire_r = vecs[i].fire_r; p1_joy = vecs[i].joy;
      tick(2);
      check({vecs[i].name, "_mode"}, {7'd0, mode}, {7'd0, vecs[i].joy_mode});
      do_read(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end

    // Ignored writes and non-port reads
    do_write(8'hA0);
    do_write(8'hE0);
    check("ignored_wr_mode", {7'd0, mode}, 8'h00);
    do_write(8'hC0);
    check("js_wr_mode", {7'd0, mode}, 8'h01);
    do_read("nonport_read", 8'h5C, last_exp);
    do_write(8'h80);
    check("kp_wr_mode", {7'd0, mode}, 8'h00);
    tick(3);
    check("dout_holds", io_dout, last_exp);

    // Release key 1 and let the stretcher drain
    p1_key = 4'h0; p1_joy = '0; p1_fire_r = 1'b0;
    tick(HOLD + 6);
    do_read("drained", 8'hFC, 8'h7F);

    // Stretch: one-cycle press of 3, reads 10 and 20 cycles later
    p1_key = 4'h3; tick(); p1_key = 4'h0;
    tick(9);
    do_read("stretch_10", 8'hFC, 8'h7C);
    tick(9);
    do_read("stretch_20", 8'hFC, 8'h7F);

    // Re-press during HOLD restarts the counter
    p1_key = 4'h2; tick(); p1_key = 4'h0;
    tick(5);
    p1_key = 4'h9; tick(); p1_key = 4'h0;
    tick(HOLD - 4);
    do_read("repress_hold", 8'hFC, 8'h76);
    tick(10);
    do_read("repress_expired", 8'hFC, 8'h7F);

    // Reset mid-hold clears the latched code at once
    p1_key = 4'h4; tick(); p1_key = 4'h0;
    tick(4);
    reset = 1'b1; tick(); reset = 1'b0;
    check("midhold_reset_dout", io_dout, 8'hFF);
    do_read("midhold_reset_read", 8'hFC, 8'h7F);

    // Player 2 in both modes
    p2_key = 4'hE;
    tick(2);
    do_read("p2_keypad", 8'hFF, p2_kp);
    do_write(8'hC0);
    p2_joy = 5'b00101;
    tick(2);
    do_read("p2_joystick", 8'hFE, p2_js);
    do_read("p1_after_p2", 8'hFC, 8'h7F);
    do_write(8'h80);
    check("final_mode", {7'd0, mode}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
